// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RISC-V load/store width codes and access-size decode.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Access size in bytes; the low two bits of funct3 carry the width, so 111 is a doubleword.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

  // Offset bits that must be zero for a naturally aligned access of this width.
  function automatic logic [2:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_mask = 3'b000;
      2'b01:   size_mask = 3'b001;
      2'b10:   size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte lane steering for the load/store unit: load extract with sign/zero
// extension, and the sub-doubleword store merge into a read doubleword.
// Purely combinational; the sequencing lives in lsu_mem_stage.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [63:0] dword,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_data
);

  logic [63:0] rshift;
  logic [63:0] wshift;
  logic [3:0]  size;
  logic [7:0]  byte_en;

  // Bring the addressed byte down to lane 0 for loads, push store bytes up to their lane.
  assign rshift = dword >> {offset, 3'b000};
  assign wshift = wdata << {offset, 3'b000};
  assign size   = size_bytes(funct3);

  // Load result: keep the access width and extend per the unsigned bit of funct3.
  always_comb begin
    load_data = rshift;
    case (funct3)
      F3_LB:   load_data = {{56{rshift[7]}},  rshift[7:0]};
      F3_LH:   load_data = {{48{rshift[15]}}, rshift[15:0]};
      F3_LW:   load_data = {{32{rshift[31]}}, rshift[31:0]};
      F3_LD:   load_data = rshift;
      F3_LBU:  load_data = {56'd0, rshift[7:0]};
      F3_LHU:  load_data = {48'd0, rshift[15:0]};
      F3_LWU:  load_data = {32'd0, rshift[31:0]};
      default: load_data = rshift;
    endcase
  end

  // Store merge: each lane inside [offset, offset+size) takes new data, the rest keep the base.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      assign byte_en[gi] = (4'(gi) >= {1'b0, offset}) &&
                           (4'(gi) < ({1'b0, offset} + size));
      assign store_data[8*gi +: 8] = byte_en[gi] ? wshift[8*gi +: 8] : dword[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: accepts one load or store, sequences the
// doubleword-aligned memory accesses (read-modify-write for sb/sh/sw) and
// returns a one-cycle response. Every output comes from registers or state.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses are
// flagged on resp_misaligned and skip memory; otherwise the offset is
// rounded down to natural alignment and resp_misaligned stays 0.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_load,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state_reg, state_next;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] data_reg;
  logic [2:0]      funct3_reg;
  logic            load_reg;
  logic            misaligned_reg;

  logic            accept;
  logic            req_misaligned;
  logic [2:0]      offset;
  logic [63:0]     load_data;
  logic [63:0]     store_data;

  assign accept = req_valid && (state_reg == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misaligned = (req_load || req_store) &&
                          ((req_addr[2:0] & size_mask(req_funct3)) != 3'b000);
`else
  assign req_misaligned = 1'b0;
`endif

  // Misaligned requests never reach memory when trapping, so rounding down is
  // harmless there and gives natural alignment in the non-trapping build.
  assign offset = addr_reg[2:0] & ~size_mask(funct3_reg);

  lsu_align u_align (
    .offset     (offset),
    .funct3     (funct3_reg),
    .dword      (data_reg),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_misaligned || !(req_load || req_store)) begin
            state_next = ST_RESP;
          end else if (req_store) begin
            state_next = (size_bytes(req_funct3) == 4'd8) ? ST_WRITE : ST_RMW_READ;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        mem_read   = 1'b1;
        state_next = ST_RESP;
      end
      ST_RMW_READ: begin
        mem_read   = 1'b1;
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        mem_write  = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture on accept and memory data capture during read cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg       <= '0;
      wdata_reg      <= '0;
      data_reg       <= '0;
      funct3_reg     <= 3'b000;
      load_reg       <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg       <= req_addr;
        wdata_reg      <= req_wdata;
        funct3_reg     <= req_funct3;
        load_reg       <= req_load && !req_store;
        misaligned_reg <= req_misaligned;
      end
      if (state_reg == ST_LOAD || state_reg == ST_RMW_READ) begin
        data_reg <= mem_rdata;
      end
    end
  end

  assign mem_addr        = {addr_reg[XLEN-1:3], 3'b000};
  assign mem_wdata       = (state_reg == ST_WRITE) ? store_data : '0;
  assign resp_rdata      = (state_reg == ST_RESP && load_reg && !misaligned_reg) ? load_data : '0;
  assign resp_misaligned = (state_reg == ST_RESP) && misaligned_reg;

endmodule
